// File: rtl/mac_vector_accumulator_pkg.sv
// mac_pkg: shared types and helpers for the vector multiply-accumulate block.
//   state_e       - control FSM states (idle, accumulating, draining, holding a result)
//   clog2         - ceiling log2 used to size the reduction tree
//   prod_width    - width of one full-precision signed product
//   tree_width    - width of the reduced sum of all lanes
//   sat_to_result - clip a signed accumulator value into a narrower signed result
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StHold
  } state_e;

  // Widest accumulator the saturation helper handles; callers sign-extend into it.
  // RESULT_WIDTH is expected to be strictly below this.
  localparam int unsigned SatMaxWidth = 64;

  typedef struct packed {
    logic                          sat;
    logic signed [SatMaxWidth-1:0] value;
  } sat_result_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned prod_width(input int unsigned dw, input int unsigned ww);
    return dw + ww;
  endfunction

  // The tree adds one bit of growth per level.
  function automatic int unsigned tree_width(input int unsigned pw, input int unsigned lanes);
    return pw + clog2(lanes);
  endfunction

  // Only the low result_width bits of .value are meaningful to the caller.
  function automatic sat_result_t sat_to_result(input logic signed [SatMaxWidth-1:0] acc,
                                                input int unsigned result_width);
    logic signed [SatMaxWidth-1:0] max_v;
    logic signed [SatMaxWidth-1:0] min_v;
    sat_result_t r;
    max_v   = (64'sd1 <<< (result_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (result_width - 1));
    r.sat   = 1'b0;
    r.value = acc;
    if (acc > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v;
    end else if (acc < min_v) begin
      r.sat   = 1'b1;
      r.value = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_vector_accumulator_if.sv
// Stream bundle between the layer sequencer, the accumulator and the activation stage.
//   in_valid/in_ready/in_last      - beat handshake and end-of-vector marker
//   bias_value                     - per-vector signed bias (used on the first beat only)
//   input_vector/weight_vector     - LANES packed signed elements, lane i at [i*W +: W]
//   out_valid/out_ready            - result handshake
//   output_value/saturated         - saturated signed result and clip flag
// master: sequencer/consumer side; slave: the accumulator.
interface mac_vector_accumulator_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned RESULT_WIDTH = 16
) ();

  logic                             in_valid;
  logic                             in_ready;
  logic                             in_last;
  logic signed [RESULT_WIDTH-1:0]   bias_value;
  logic [LANES*DATA_WIDTH-1:0]      input_vector;
  logic [LANES*WEIGHT_WIDTH-1:0]    weight_vector;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [RESULT_WIDTH-1:0]   output_value;
  logic                             saturated;

  modport master (
    output in_valid, in_last, bias_value, input_vector, weight_vector, out_ready,
    input  in_ready, out_valid, output_value, saturated
  );

  modport slave (
    input  in_valid, in_last, bias_value, input_vector, weight_vector, out_ready,
    output in_ready, out_valid, output_value, saturated
  );

endinterface

// File: rtl/mac_vector_accumulator_adder_tree.sv
// mac_adder_tree: registered-input signed reduction of LANES values.
//   clk, reset_n - clock, asynchronous active-low reset
//   load         - capture products into the input register
//   products     - LANES packed signed values of IN_WIDTH bits
//   sum          - signed sum of the registered values, IN_WIDTH+clog2(LANES) bits
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_WIDTH  = 16,
  localparam int unsigned OUT_WIDTH = IN_WIDTH + clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic [LANES*IN_WIDTH-1:0]   products,
  output logic signed [OUT_WIDTH-1:0] sum
);

  localparam int unsigned Levels = clog2(LANES);
  localparam int unsigned Nodes  = 1 << Levels;

  logic [LANES*IN_WIDTH-1:0] prod_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
    end else if (load) begin
      prod_q <= products;
    end
  end

  // Level 0 holds the leaves (padded with zeros to a power of two); each further level
  // halves the node count and widens by one bit so no pairwise sum can overflow.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned LvlWidth = IN_WIDTH + l;
    localparam int unsigned LvlNodes = Nodes >> l;
    logic [LvlWidth-1:0] node [LvlNodes];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LvlNodes; i++) begin : g_n
        if (i < LANES) begin : g_lane
          assign node[i] = prod_q[i*IN_WIDTH +: IN_WIDTH];
        end else begin : g_pad
          assign node[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < LvlNodes; i++) begin : g_n
        logic [LvlWidth-2:0] a;
        logic [LvlWidth-2:0] b;
        assign a       = g_lvl[l-1].node[2*i];
        assign b       = g_lvl[l-1].node[2*i+1];
        assign node[i] = {a[LvlWidth-2], a} + {b[LvlWidth-2], b};
      end
    end
  end

  assign sum = g_lvl[Levels].node[0];

endmodule

// File: rtl/mac_vector_accumulator.sv
// mac_vector_accumulator: pipelined LANES-wide signed dot product with bias and saturation.
//   clk, reset_n - clock, asynchronous active-low reset
//   soft_clear   - synchronous abort of the current vector (highest priority)
//   bus (slave)  - beat stream in, result stream out (see mac_vector_accumulator_if)
// Pipeline: stage 1 = registered products (inside the tree), stage 2 = accumulator,
// then the saturated output register loaded on entry to StHold.
module mac_vector_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned RESULT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  input logic                     soft_clear,
  mac_vector_accumulator_if.slave bus
);

  localparam int unsigned ProdWidth = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
  localparam int unsigned TreeWidth = tree_width(ProdWidth, LANES);

  state_e state_q, state_d;

  logic                           ready_en_q;
  logic                           accept;
  logic                           first_beat;
  logic                           load_out;

  logic [LANES*ProdWidth-1:0]     prod_flat;
  logic signed [TreeWidth-1:0]    tree_sum;

  logic                           s1_valid_q;
  logic                           s1_first_q;
  logic                           s1_last_q;
  logic signed [RESULT_WIDTH-1:0] s1_bias_q;

  logic                           s2_last_q;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;

  logic signed [RESULT_WIDTH-1:0] out_value_q;
  logic                           out_sat_q;

  sat_result_t                    sat_res;
  logic                           unused_sat_hi;

  // in_ready stays low while reset is held and rises on the first clock after release.
  assign bus.in_ready = ready_en_q && ((state_q == StIdle) || (state_q == StAccum));
  assign accept       = bus.in_valid && bus.in_ready && !soft_clear;
  assign first_beat   = (state_q == StIdle);

  for (genvar l = 0; l < LANES; l++) begin : g_prod
    logic signed [DATA_WIDTH-1:0]   x;
    logic signed [WEIGHT_WIDTH-1:0] w;
    assign x = bus.input_vector[l*DATA_WIDTH +: DATA_WIDTH];
    assign w = bus.weight_vector[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign prod_flat[l*ProdWidth +: ProdWidth] = ProdWidth'(x) * ProdWidth'(w);
  end

  mac_adder_tree #(
    .LANES    (LANES),
    .IN_WIDTH (ProdWidth)
  ) u_tree (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .products (prod_flat),
    .sum      (tree_sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Stage 1 side-band: travels alongside the registered products in the tree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bias_q  <= '0;
    end else if (soft_clear) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= first_beat;
        s1_last_q  <= bus.in_last;
        if (first_beat) begin
          s1_bias_q <= bus.bias_value;
        end
      end
    end
  end

  // Stage 2: a first beat restarts from the bias; bubbles leave the accumulator alone.
  always_comb begin
    acc_d = acc_q;
    if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_d = ACC_WIDTH'(s1_bias_q) + ACC_WIDTH'(tree_sum);
      end else begin
        acc_d = acc_q + ACC_WIDTH'(tree_sum);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      s2_last_q <= 1'b0;
    end else if (soft_clear) begin
      acc_q     <= '0;
      s2_last_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      s2_last_q <= s1_valid_q && s1_last_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    if (soft_clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = bus.in_last ? StDrain : StAccum;
          end
        end
        StAccum: begin
          if (accept && bus.in_last) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          // s2_last_q means acc_q now holds the finished dot product.
          if (s2_last_q) begin
            state_d  = StHold;
            load_out = 1'b1;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign sat_res       = sat_to_result(SatMaxWidth'(acc_q), RESULT_WIDTH);
  assign unused_sat_hi = ^sat_res.value[SatMaxWidth-1:RESULT_WIDTH];

  // Result registers keep their value after the handshake until the next result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_value_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (load_out) begin
      out_value_q <= sat_res.value[RESULT_WIDTH-1:0];
      out_sat_q   <= sat_res.sat;
    end
  end

  assign bus.out_valid    = (state_q == StHold);
  assign bus.output_value = out_value_q;
  assign bus.saturated    = out_sat_q;

endmodule

// File: tb/tb_mac_vector_accumulator.sv
// Directed bench for mac_vector_accumulator (LANES=4, 8-bit data/weights, ACC 32, RESULT 16).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_mac_vector_accumulator;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 16;

  typedef int lane_t [LN];

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic soft_clear = 1'b0;

  int cyc     = 0;
  int total   = 0;
  int bad     = 0;
  int acc_cyc = 0;
  int hs_cyc  = 0;

  mac_vector_accumulator_if #(
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW),
    .LANES        (LN),
    .RESULT_WIDTH (RW)
  ) bus ();

  mac_vector_accumulator #(
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW),
    .LANES        (LN),
    .ACC_WIDTH    (AW),
    .RESULT_WIDTH (RW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .soft_clear (soft_clear),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_data(input lane_t x, input lane_t w, input int bias, input bit last);
    logic [LN*DW-1:0] iv;
    logic [LN*WW-1:0] wv;
    for (int i = 0; i < LN; i++) begin
      iv[i*DW +: DW] = DW'(x[i]);
      wv[i*WW +: WW] = WW'(w[i]);
    end
    bus.input_vector  = iv;
    bus.weight_vector = wv;
    bus.bias_value    = RW'(bias);
    bus.in_last       = last;
  endtask

  // Called on a falling edge; returns on the falling edge after the beat is taken.
  // acc_cyc is the cycle in which the beat is presented with in_ready high.
  task automatic send_beat(input lane_t x, input lane_t w, input int bias, input bit last);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check_eq("accept_timeout", longint'(bus.in_ready), 1);
    drive_data(x, w, bias, last);
    bus.in_valid = 1'b1;
    acc_cyc      = cyc;
    @(negedge clk);
  endtask

  // Waits for the result, optionally holds out_ready low for 'hold' cycles while
  // offering junk beats, then completes the handshake.
  task automatic wait_result(input string tag, input int exp, input bit exp_sat,
                             input int hold);
    int n = 0;
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, longint'(bus.out_valid), 1);
    check_eq({tag, "_latency"}, cyc - acc_cyc, 3);
    check_eq({tag, "_value"}, bus.output_value, exp);
    check_eq({tag, "_sat"}, longint'(bus.saturated), exp_sat);
    for (int k = 0; k < hold; k++) begin
      drive_data('{100, 100, 100, 100}, '{-100, -100, -100, -100}, 77, 1'b1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_hold_value"}, bus.output_value, exp);
      check_eq({tag, "_hold_sat"}, longint'(bus.saturated), exp_sat);
      check_eq({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
      check_eq({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    hs_cyc        = cyc;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "_drop"}, longint'(bus.out_valid), 0);
    check_eq({tag, "_keep"}, bus.output_value, exp);
  endtask

  task automatic run_single(input string tag);
    send_beat('{1, 2, 3, 4}, '{1, 1, 1, 1}, 10, 1'b1);
    wait_result(tag, 20, 1'b0, 0);
  endtask

  task automatic count_stray(input string tag);
    int seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_last       = 1'b0;
    bus.bias_value    = '0;
    bus.input_vector  = '0;
    bus.weight_vector = '0;
    bus.out_ready     = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("reset_in_ready", longint'(bus.in_ready), 0);
    check_eq("reset_out_valid", longint'(bus.out_valid), 0);
    check_eq("reset_value", bus.output_value, 0);
    check_eq("reset_sat", longint'(bus.saturated), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("release_in_ready_low", longint'(bus.in_ready), 0);
    @(negedge clk);
    check_eq("release_in_ready_high", longint'(bus.in_ready), 1);

    // 1: single beat, 10 + (1+2+3+4) = 20
    run_single("single");

    // 2: 3 beats of 4*16384 = 196608 -> clipped high
    for (int b = 0; b < 3; b++) begin
      send_beat('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0, b == 2);
    end
    wait_result("pos_sat", 32767, 1'b1, 0);

    // 3: 2 * 4 * (127*-128) + 5 = -130043 -> clipped low; second bias ignored
    send_beat('{127, 127, 127, 127}, '{-128, -128, -128, -128}, 5, 1'b0);
    send_beat('{127, 127, 127, 127}, '{-128, -128, -128, -128}, 999, 1'b1);
    wait_result("neg_sat", -32768, 1'b1, 0);

    // 4: backpressure, then back-to-back vectors
    send_beat('{1, 2, 3, 4}, '{1, 1, 1, 1}, 10, 1'b1);
    wait_result("bp", 20, 1'b0, 5);
    // -2 - 15 + 0 + 7 = -10, bias -3
    send_beat('{-1, 5, 0, 7}, '{2, -3, 4, 1}, -3, 1'b1);
    check_eq("bp_next_accept", acc_cyc, hs_cyc + 1);
    wait_result("b2b_b", -13, 1'b0, 0);
    // (10-20+30-40) + 100 + bias 100 = 180
    send_beat('{10, 20, 30, 40}, '{1, -1, 1, -1}, 100, 1'b0);
    send_beat('{50, 0, 0, 0}, '{2, 0, 0, 0}, -50, 1'b1);
    wait_result("b2b_c", 180, 1'b0, 0);

    // 5: 3 * 24 - 1 = 71, gap-free then with 2-cycle bubbles
    for (int b = 0; b < 3; b++) begin
      send_beat('{2, 2, 2, 2}, '{3, 3, 3, 3}, (b == 0) ? -1 : 7, b == 2);
    end
    wait_result("nogap", 71, 1'b0, 0);
    for (int b = 0; b < 3; b++) begin
      send_beat('{2, 2, 2, 2}, '{3, 3, 3, 3}, (b == 0) ? -1 : 7, b == 2);
      if (b < 2) begin
        bus.in_valid = 1'b0;
        drive_data('{99, 99, 99, 99}, '{99, 99, 99, 99}, 50, 1'b1);
        repeat (2) @(negedge clk);
      end
    end
    wait_result("gap", 71, 1'b0, 0);

    // 6a: asynchronous reset mid-vector
    send_beat('{100, 100, 100, 100}, '{100, 100, 100, 100}, 0, 1'b0);
    bus.in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_in_ready", longint'(bus.in_ready), 0);
    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_value", bus.output_value, 0);
    check_eq("rst_sat", longint'(bus.saturated), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rst_release_in_ready_low", longint'(bus.in_ready), 0);
    @(negedge clk);
    check_eq("rst_release_in_ready_high", longint'(bus.in_ready), 1);
    count_stray("rst_no_stale");
    run_single("rst_recover");

    // 6b: soft_clear in ACCUM, with a last beat presented in the same cycle
    send_beat('{100, 100, 100, 100}, '{100, 100, 100, 100}, 0, 1'b0);
    soft_clear = 1'b1;
    drive_data('{1, 2, 3, 4}, '{1, 1, 1, 1}, 10, 1'b1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    soft_clear   = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("clr_in_ready", longint'(bus.in_ready), 1);
    count_stray("clr_no_result");
    run_single("clr_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_vector_accumulator.md
Name: mac_vector_accumulator

Overview:
- Parametrised, pipelined successor to the scalar multiply-add element.
- Each beat takes LANES input/weight pairs, multiplies them in parallel, reduces them with an adder tree, and accumulates across beats until in_last.
- Starts each dot product from a per-vector bias and returns a saturated signed result over a valid/ready handshake.
- Sits between the layer sequencer (vector/weight streams) and the activation stage.

Parameters:
- DATA_WIDTH, 8: signed input element width.
- WEIGHT_WIDTH, 8: signed weight element width.
- LANES, 4: parallel products per beat (>=1).
- ACC_WIDTH, 32: internal accumulator width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES)+1.
- RESULT_WIDTH, 16: signed output width; must be <= ACC_WIDTH.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- soft_clear, input, 1: synchronous abort of the current vector.
- in_valid, input, 1: beat valid.
- in_ready, output, 1: beat accepted when in_valid && in_ready.
- in_last, input, 1: final beat of the current vector.
- bias_value, input, RESULT_WIDTH: signed; sampled only on the first beat of a vector.
- input_vector, input, LANES*DATA_WIDTH: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- weight_vector, input, LANES*WEIGHT_WIDTH: same packing as input_vector, signed.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- output_value, output, RESULT_WIDTH: saturated signed dot product plus bias.
- saturated, output, 1: output_value was clipped; qualified by out_valid.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, in_ready=0 during reset and 1 from the first clock after release, out_valid=0, output_value=0, saturated=0, all pipeline valids cleared.
- States:
  - IDLE: waiting for the first beat of a vector.
  - ACCUM: vector in progress.
  - DRAIN: last beat accepted, pipeline flushing.
  - HOLD: result presented on the output.
- Transitions:
  - IDLE: accepted beat -> ACCUM, or -> DRAIN if in_last.
  - ACCUM: accepted beat with in_last -> DRAIN.
  - DRAIN: -> HOLD when the last beat leaves stage 2.
  - HOLD: out_valid && out_ready -> IDLE.
- in_ready is 1 in IDLE and ACCUM, 0 in DRAIN and HOLD. in_valid is ignored while in_ready=0.
- Pipeline:
  - Stage 1 registers the LANES sign-extended products.
  - Stage 2 adds the adder-tree sum to the accumulator. On a first beat, the accumulator is loaded with sign-extended bias + sum instead.
  - Bubbles (in_valid=0) in ACCUM leave the accumulator unchanged.
- Latency: last beat accepted at cycle N -> out_valid=1 at cycle N+3. Throughput is one beat per cycle inside a vector.
- Arithmetic: full-precision signed products; the tree grows one bit per level; the accumulator wraps modulo 2^ACC_WIDTH (parameter rule guarantees headroom for intended depths).
- Output saturation:
  - acc > 2^(RESULT_WIDTH-1)-1 -> max, saturated=1.
  - acc < -2^(RESULT_WIDTH-1) -> min, saturated=1.
  - Otherwise truncate, saturated=0.
- Output registers are loaded on entering HOLD and stay stable while out_valid && !out_ready.
- out_valid drops the cycle after the handshake; output_value holds its last value. A new beat can be accepted in the cycle after the handshake.
- soft_clear (synchronous, has priority over all other events):
  - State returns to IDLE; pipeline valids, accumulator and out_valid are cleared.
  - A beat presented in the same cycle is discarded.
- Reset mid-vector: partial sum is lost, no result is produced.
- LANES=1 degenerates to a pipelined scalar MAC.

Decomposition:
- Package mac_pkg holds:
  - the state enum (IDLE/ACCUM/DRAIN/HOLD);
  - the function clog2;
  - functions for the product and tree widths;
  - the saturation function sat_to_result(acc).
- One sub-module, mac_adder_tree: parametrised (LANES, IN_WIDTH), registered-input signed reduction tree producing IN_WIDTH+clog2(LANES) bits.

Test Plan (LANES=4, DATA/WEIGHT=8, ACC=32, RESULT=16):
1. Single beat: bias=10, inputs {1,2,3,4}, weights {1,1,1,1}, in_last=1 -> output_value=20, saturated=0, out_valid exactly 3 cycles after acceptance.
2. Positive saturation: 3 beats, all inputs -128, weights -128, bias 0 -> internal sum 196608 -> output_value=32767, saturated=1.
3. Negative saturation and bias sampling: 2 beats, inputs 127, weights -128, bias=5 on beat 1 and bias=999 on beat 2 -> -130043 -> output_value=-32768, saturated=1; bias 999 is ignored.
4. Backpressure: out_ready held low 5 cycles after out_valid:
   - output_value and saturated stay stable; in_ready=0; in_valid beats are ignored.
   - On out_ready=1, the next vector's first beat is accepted the following cycle.
   - Back-to-back vectors give the correct independent results.
5. Bubbles: vector {2,2,2,2}x{3,3,3,3} over 3 beats with 2-cycle in_valid gaps, bias=-1 -> 71; result identical to the gap-free run.
6. Aborts:
   - reset_n pulsed low mid-vector -> all outputs 0 immediately (asynchronously), no stale result; the next vector (test 1 stimulus) gives 20.
   - soft_clear in ACCUM -> same recovery.
